// File: rtl/pwm_decoder.sv
// Measures high time and rise-to-rise period of an asynchronous PWM input in prescaled ticks.
// A new measurement is latched on every rise after a complete period; loss of signal drops to IDLE.
module pwm_decoder #(
    parameter int PRESCALER_DIV = 4096,
    parameter int CNTWIDTH      = 16,
    parameter int DUTYWIDTH     = 8,
    parameter int DUTYLOW       = 26,
    parameter int DUTYHIGH      = 51,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 PWM_in,
    output logic [DUTYWIDTH-1:0] DUTY,
    output logic [CNTWIDTH-1:0]  HIGH_TIME,
    output logic [CNTWIDTH-1:0]  PERIOD,
    output logic                 VALID,
    output logic                 IN_RANGE,
    output logic                 TIMEOUT,
    output logic                 LOCKED
);
    localparam int DIVW = (PRESCALER_DIV > 1) ? $clog2(PRESCALER_DIV) : 1;
    localparam logic [DIVW-1:0]     DIV_LAST = DIVW'(PRESCALER_DIV - 1);
    localparam logic [CNTWIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNTWIDTH-1:0] TO_LIM   = CNTWIDTH'(TIMEOUT_TICKS);
    localparam logic [CNTWIDTH:0]   DUTY_MAX = (CNTWIDTH+1)'(2**DUTYWIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    state_t              state, state_nxt;
    logic                sync1, sync2, prev;
    logic                rise, fall, tick;
    logic [DIVW-1:0]     div_cnt;
    logic [CNTWIDTH-1:0] period_cnt, high_cnt, period_nxt, high_nxt;
    logic [CNTWIDTH-1:0] period_inc, high_inc, restart;
    logic                latch, to_hit;
    logic [DUTYWIDTH-1:0] duty_sat;
    logic                in_range_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= PWM_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // An event-cycle tick is counted in the interval that starts at that event.
    assign restart    = CNTWIDTH'(tick);
    assign period_inc = (tick && period_cnt != CNT_MAX) ? period_cnt + 1'b1 : period_cnt;
    assign high_inc   = (tick && high_cnt   != CNT_MAX) ? high_cnt   + 1'b1 : high_cnt;
    assign to_hit     = (state != S_IDLE) && (period_cnt >= TO_LIM);

    always_comb begin
        state_nxt  = state;
        period_nxt = period_cnt;
        high_nxt   = high_cnt;
        latch      = 1'b0;
        case (state)
            S_IDLE: if (rise) begin
                state_nxt  = S_HIGH;
                period_nxt = restart;
                high_nxt   = restart;
            end
            S_HIGH: begin
                period_nxt = period_inc;
                if (fall) state_nxt = S_LOW;
                else      high_nxt  = high_inc;
            end
            S_LOW: if (rise) begin
                state_nxt  = S_HIGH;
                latch      = 1'b1;
                period_nxt = restart;
                high_nxt   = restart;
            end else begin
                period_nxt = period_inc;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Timeout beats a coincident rise; counters clear, last results stay on the outputs.
        if (to_hit) begin
            state_nxt  = S_IDLE;
            period_nxt = '0;
            high_nxt   = '0;
            latch      = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            period_cnt <= period_nxt;
            high_cnt   <= high_nxt;
        end
    end

    assign duty_sat     = ({1'b0, high_cnt} > DUTY_MAX) ? '1 : high_cnt[DUTYWIDTH-1:0];
    assign in_range_nxt = (duty_sat >= DUTYWIDTH'(DUTYLOW)) && (duty_sat <= DUTYWIDTH'(DUTYHIGH));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DUTY      <= '0;
            HIGH_TIME <= '0;
            PERIOD    <= '0;
            VALID     <= 1'b0;
            IN_RANGE  <= 1'b0;
            TIMEOUT   <= 1'b0;
            LOCKED    <= 1'b0;
        end else begin
            VALID <= latch;
            if (latch) begin
                HIGH_TIME <= high_cnt;
                PERIOD    <= period_cnt;
                DUTY      <= duty_sat;
                IN_RANGE  <= in_range_nxt;
                LOCKED    <= 1'b1;
                TIMEOUT   <= 1'b0;
            end else if (to_hit) begin
                LOCKED  <= 1'b0;
                TIMEOUT <= 1'b1;
            end
        end
    end
endmodule
